// File: rtl/doodle_pkg.sv
// Shared sprite geometry, colour key and pose types for the doodle sprite reader.
package doodle_pkg;
  localparam int          SPR_W         = 32;
  localparam int          SPR_H         = 32;
  localparam logic [23:0] KEY_COLOR     = 24'hFF00FF;
  localparam int          CROUCH_FRAMES = 6;
  localparam int          CNT_W         = $clog2(CROUCH_FRAMES + 1);

  typedef enum logic {STAND, CROUCH} pose_state_t;
  typedef logic [1:0] pose_sel_t;
endpackage

// File: rtl/doodle_pose_fsm.sv
// Crouch animation FSM: a landing holds the crouch pose for CROUCH_FRAMES frames.
module doodle_pose_fsm
  import doodle_pkg::*;
(
  input  logic Clk,
  input  logic Reset,
  input  logic frame_start,
  input  logic land_pulse,
  output logic crouch
);
  pose_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             pending, pending_nxt;
  logic             land_due;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= STAND;
      cnt     <= '0;
      pending <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pending <= pending_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    land_due    = pending | land_pulse;
    pending_nxt = land_due;
    // Landings only take effect at frame boundaries so the pose never tears.
    if (frame_start) begin
      pending_nxt = 1'b0;
      case (state)
        STAND: if (land_due) begin
          state_nxt = CROUCH;
          cnt_nxt   = CNT_W'(CROUCH_FRAMES);
        end
        CROUCH: if (land_due) begin
          cnt_nxt = CNT_W'(CROUCH_FRAMES);
        end else if (cnt == CNT_W'(1)) begin
          state_nxt = STAND;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
        default: state_nxt = STAND;
      endcase
    end
  end

  assign crouch = (state == CROUCH);
endmodule

// File: rtl/doodle_sprite_reader.sv
// Sprite RAM read engine: VGA pixel -> RAM address, 3-cycle aligned colour/opaque output.
// Define DOODLE_MIRROR_EN to build left poses by mirroring the right-facing RAMs.
module doodle_sprite_reader
  import doodle_pkg::*;
#(
  parameter int ADDR_W = 11
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_start,
  input  logic              pixel_valid,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        doodle_x,
  input  logic [9:0]        doodle_y,
  input  logic              facing_left,
  input  logic              land_pulse,
  output logic [ADDR_W-1:0] read_address,
  output logic [1:0]        pose_sel,
  input  logic [23:0]       sprite_data,
  output logic [23:0]       pixel_rgb,
  output logic              pixel_hit,
  output logic              pixel_valid_out
);
  localparam int STAGES = 2;

  logic [9:0]        sx, sy;
  logic              sleft;
  logic              crouch;
  logic [10:0]       rel_x, rel_y, x_term, addr_full;
  logic              in_box;
  logic [STAGES:1]   vld_pipe, box_pipe;
  pose_sel_t         pose;

  // Position/facing are only sampled at frame start to avoid mid-frame tearing.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sx    <= '0;
      sy    <= '0;
      sleft <= 1'b0;
    end else if (frame_start) begin
      sx    <= doodle_x;
      sy    <= doodle_y;
      sleft <= facing_left;
    end
  end

  doodle_pose_fsm u_pose (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_start (frame_start),
    .land_pulse  (land_pulse),
    .crouch      (crouch)
  );

  // Unsigned wrap makes DrawX < sx land far outside the box.
  assign rel_x  = {1'b0, DrawX} - {1'b0, sx};
  assign rel_y  = {1'b0, DrawY} - {1'b0, sy};
  assign in_box = pixel_valid & (rel_x < 11'(SPR_W)) & (rel_y < 11'(SPR_H));

`ifdef DOODLE_MIRROR_EN
  assign x_term = sleft ? (11'(SPR_W - 1) - rel_x) : rel_x;
  assign pose   = {crouch, 1'b0};
`else
  assign x_term = rel_x;
  assign pose   = {crouch, sleft};
`endif

  assign addr_full = rel_y * 11'(SPR_W) + x_term;
  assign pose_sel  = pose;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      read_address    <= '0;
      vld_pipe        <= '0;
      box_pipe        <= '0;
      pixel_rgb       <= '0;
      pixel_hit       <= 1'b0;
      pixel_valid_out <= 1'b0;
    end else begin
      if (in_box) read_address <= ADDR_W'(addr_full);
      vld_pipe        <= {vld_pipe[1], pixel_valid};
      box_pipe        <= {box_pipe[1], in_box};
      pixel_rgb       <= sprite_data;
      pixel_hit       <= box_pipe[2] & (sprite_data != KEY_COLOR);
      pixel_valid_out <= vld_pipe[2];
    end
  end
endmodule

// File: tb/tb_doodle_sprite_reader.sv
// Randomized bench for doodle_sprite_reader against a frame/pixel-level reference model.
module tb_doodle_sprite_reader;
  localparam logic [23:0] KEY = 24'hFF00FF;
`ifdef DOODLE_MIRROR_EN
  localparam bit MIR = 1'b1;
`else
  localparam bit MIR = 1'b0;
`endif

  logic        Clk = 1'b0, Reset = 1'b1;
  logic        frame_start = 0, pixel_valid = 0, facing_left = 0, land_pulse = 0;
  logic [9:0]  DrawX = '0, DrawY = '0, doodle_x = '0, doodle_y = '0;
  logic [10:0] read_address;
  logic [1:0]  pose_sel;
  logic [23:0] sprite_data = '0, pixel_rgb;
  logic        pixel_hit, pixel_valid_out;

  int n_chk = 0, n_err = 0;

  doodle_sprite_reader dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .pixel_valid(pixel_valid),
    .DrawX(DrawX), .DrawY(DrawY), .doodle_x(doodle_x), .doodle_y(doodle_y),
    .facing_left(facing_left), .land_pulse(land_pulse), .read_address(read_address),
    .pose_sel(pose_sel), .sprite_data(sprite_data), .pixel_rgb(pixel_rgb),
    .pixel_hit(pixel_hit), .pixel_valid_out(pixel_valid_out)
  );

  always #5 Clk = ~Clk;

  function automatic logic [23:0] ram_word(input logic [10:0] a, input logic [1:0] p);
    if (a % 7 == 3) return KEY;
    return {p, a, 11'(a * 37 + 5)};
  endfunction

  // Registered-read sprite RAM, already muxed by pose.
  always @(posedge Clk) sprite_data <= ram_word(read_address, pose_sel);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct { bit vld; bit box; int addr; bit [1:0] pose; } exp_t;
  exp_t q[$];
  int   m_sx, m_sy, m_frames, m_addr;
  bit   m_left, m_pend;

  function automatic int m_pose();
    return ((m_frames > 0) ? 2 : 0) + ((MIR || !m_left) ? 0 : 1);
  endfunction

  task automatic step(input bit fs, input bit land, input bit pv, input int x, input int y);
    exp_t e;
    int rx, ry;
    @(negedge Clk);
    chk("pose_sel", pose_sel, m_pose());
    chk("read_address", read_address, m_addr);
    if (q.size() == 3) begin
      e = q.pop_front();
      chk("valid_out", pixel_valid_out, e.vld);
      chk("hit", pixel_hit, e.box && (ram_word(11'(e.addr), e.pose) != KEY));
      if (e.box) chk("rgb", pixel_rgb, ram_word(11'(e.addr), e.pose));
    end
    frame_start = fs; land_pulse = land; pixel_valid = pv;
    DrawX = 10'(x); DrawY = 10'(y);
    rx = (x - m_sx) & 2047;
    ry = (y - m_sy) & 2047;
    e.vld = pv;
    e.box = pv && rx < 32 && ry < 32;
    if (e.box) m_addr = ry * 32 + ((MIR && m_left) ? 31 - rx : rx);
    e.addr = m_addr;
    e.pose = 2'(m_pose());
    q.push_back(e);
    if (fs) begin
      if (m_pend || land) m_frames = 6;
      else if (m_frames > 0) m_frames--;
      m_pend = 0;
      m_sx = doodle_x; m_sy = doodle_y; m_left = facing_left;
    end else if (land) m_pend = 1;
  endtask

  task automatic do_reset();
    exp_t e;
    @(negedge Clk);
    Reset = 1; frame_start = 0; land_pulse = 0; pixel_valid = 0;
    @(negedge Clk);
    chk("rst_rgb", pixel_rgb, 0);
    chk("rst_hit", pixel_hit, 0);
    chk("rst_vld", pixel_valid_out, 0);
    chk("rst_addr", read_address, 0);
    chk("rst_pose", pose_sel, 0);
    Reset = 0;
    m_sx = 0; m_sy = 0; m_left = 0; m_frames = 0; m_pend = 0; m_addr = 0;
    q.delete();
    e.vld = 0; e.box = 0; e.addr = 0; e.pose = 0;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic stream(input int n, input int x0, input int xs, input int y0, input int ys);
    for (int i = 0; i < n; i++)
      step(0, 0, ($urandom % 4) != 0, x0 + int'($urandom % xs), y0 + int'($urandom % ys));
  endtask

  initial begin
    do_reset();
    doodle_x = 100; doodle_y = 200; facing_left = 0;
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 100, 200);
    step(0, 0, 1, 131, 231);
    step(0, 0, 1, 132, 200);
    step(0, 0, 1, 99, 200);
    step(0, 0, 1, 103, 200);
    step(0, 0, 1, 101, 200);
    step(0, 0, 0, 100, 200);
    step(0, 0, 1, 100, 232);
    idle(3);
    stream(200, 90, 50, 190, 50);
    idle(3);

    step(0, 1, 0, 0, 0);
    for (int f = 1; f <= 7; f++) begin step(1, 0, 0, 0, 0); idle(2); end
    facing_left = 1;
    step(0, 1, 0, 0, 0);
    for (int f = 1; f <= 10; f++) begin step(1, f == 3, 0, 0, 0); idle(2); end
    stream(120, 90, 50, 190, 50);
    idle(3);

    doodle_x = 300; facing_left = 0;
    stream(100, 90, 260, 195, 40);
    idle(3);
    step(1, 0, 0, 0, 0);
    stream(100, 90, 260, 195, 40);
    idle(3);

    doodle_x = 620; doodle_y = 10;
    step(1, 0, 0, 0, 0);
    stream(80, 600, 40, 5, 40);
    stream(40, 0, 12, 5, 40);
    idle(3);

    stream(20, 610, 20, 10, 20);
    do_reset();
    stream(40, 0, 40, 0, 40);
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
